line_clear_ctrl: RTL and testbench
==================================

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 Parameter: COLS, 10, board width in cells (x = 0..COLS-1).
REQ-002 Parameter: ROWS, 20, board height in cells (y = 0..ROWS-1, y=0 top, y grows downward).
REQ-003 CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle request to scan and compact the board.
REQ-006 busy  output  1  high while a scan is in progress (board port owned by this block).
REQ-007 done  output  1  single-cycle pulse at scan completion.
REQ-008 lines_cleared  output  5  number of full rows removed by the last scan (0..ROWS).
REQ-009 board_rx  output  4  board read x address.
REQ-010 board_ry  output  5  board read y address.
REQ-011 board_rdata  input  1  cell at (board_rx, board_ry), valid one cycle after the address (synchronous read).
REQ-012 board_we  output  1  board write enable, one cell per cycle.
REQ-013 board_wx  output  4  board write x address.
REQ-014 board_wy  output  5  board write y address.
REQ-015 board_wdata  output  1  value to write (1 = occupied).

Function
REQ-016 The FSM SHALL have states IDLE, READ, EVAL, COPY, FILL, DONE.
REQ-017 Registers: src row pointer, dst row pointer, column counter, COLS-bit row buffer, cleared counter, src_exhausted flag.
REQ-018 IDLE: start=1 SHALL load src=dst=ROWS-1, column counter=0, lines_cleared=0, and go to READ; start in any other state SHALL be ignored.
REQ-019 busy SHALL be 1 in every state except IDLE; done SHALL be 1 only in DONE, which lasts one cycle and returns to IDLE.
REQ-020 READ SHALL last COLS+1 cycles: cycle k (k<COLS) drives board_rx=k, board_ry=src; cycle k+1 captures board_rdata into row buffer bit k.
REQ-021 EVAL (one cycle), full row (buffer all ones): lines_cleared+1, src-1, dst unchanged.
REQ-022 EVAL, non-full row with src==dst: src-1, dst-1, no writes.
REQ-023 EVAL, non-full row with src!=dst: go to COPY.
REQ-024 COPY SHALL last COLS cycles, cycle k driving board_we=1, board_wx=k, board_wy=dst, board_wdata=buffer[k]; then src-1, dst-1.
REQ-025 After EVAL/COPY, if the finished row was src=0 the block SHALL go to FILL when lines_cleared>0, else to DONE; otherwise it SHALL return to READ.
REQ-026 FILL SHALL write 0 to every cell of rows dst down to 0, COLS cycles per row, row by row from dst toward 0, then go to DONE.
REQ-027 Since dst>=src always, writes SHALL only target rows already read; no unread row is modified.
REQ-028 Pointer decrements past 0 SHALL NOT wrap into the scan; row-0 completion is detected before the decrement.
REQ-029 board_we SHALL be 0 outside COPY/FILL; board_rx/ry/wx/wy/wdata SHALL be 0 in IDLE and DONE, so the top level can mux the board port on busy.
REQ-030 lines_cleared SHALL hold its value from DONE until the next accepted start.
REQ-031 Scan cycle count SHALL be ROWS*(COLS+2) + COLS*(copied rows) + COLS*(filled rows), with DONE in the next cycle.

Reset
REQ-032 resetn=0 at a clock edge SHALL force IDLE, busy=0, done=0, lines_cleared=0, board_we=0, all addresses and board_wdata=0, all internal pointers/counters/buffer=0.
REQ-033 Reset mid-scan SHALL abort immediately with no further writes; board contents are then undefined; no done pulse.

Verification
REQ-034 Empty board, start pulse -> 240 cycles with board_we=0, then done=1 for one cycle, lines_cleared=0, busy=0 after.
REQ-035 Row 19 full, cell (4,18)=1 -> lines_cleared=1; (4,19)=1, row 0 zeroed, 200 writes total; all other cells 0.
REQ-036 Rows 16-19 full, cell (3,15)=1 -> lines_cleared=4; only (3,19)=1 remains; rows 0-3 written 0.
REQ-037 All 200 cells occupied -> lines_cleared=20; no COPY; FILL writes 0 to rows 19..0 (200 writes); board empty.
REQ-038 start re-asserted while busy -> ignored; exactly one done pulse; lines_cleared unchanged by the extra start.
REQ-039 resetn=0 during COPY -> next cycle busy=0, board_we=0, lines_cleared=0; no done pulse; new start afterwards scans normally.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// -----------------------------------------------------------------------------
// line_clear_ctrl
//
// Scans a COLS x ROWS falling-block board from the bottom row upward, removes
// every completely occupied row and compacts the remaining rows downward.
// Rows that vanish leave empty rows at the top, which are zero-filled at the
// end of the scan.
//
// The board is accessed through a synchronous-read port (data one cycle after
// the address) and a one-cell-per-cycle write port. All address/data outputs
// are zero whenever the block is idle, so the owner of the board can simply
// mux the port on busy.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   resetn        in   synchronous active-low reset
//   start         in   single-cycle scan request (honoured only when idle)
//   busy          out  scan in progress; this block owns the board port
//   done          out  one-cycle pulse when the scan has finished
//   lines_cleared out  number of full rows removed by the last scan
//   board_rx/ry   out  board read address (x, y)
//   board_rdata   in   cell value for the address presented last cycle
//   board_we      out  board write enable
//   board_wx/wy   out  board write address (x, y)
//   board_wdata   out  value to write (1 = occupied)
// -----------------------------------------------------------------------------
module line_clear_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
    output logic [3:0] board_rx,
    output logic [4:0] board_ry,
    input  logic       board_rdata,
    output logic       board_we,
    output logic [3:0] board_wx,
    output logic [4:0] board_wy,
    output logic       board_wdata
);

    // READ runs one cycle past the last column to collect the final read.
    localparam logic [3:0] COL_END  = 4'(COLS);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EVAL = 3'd2,
        COPY = 3'd3,
        FILL = 3'd4,
        DONE = 3'd5
    } state_t;

    // State and datapath registers
    state_t            state_r;
    logic [3:0]        col_r;
    logic [4:0]        src_r;
    logic [4:0]        dst_r;
    logic [COLS-1:0]   row_buf_r;
    logic [4:0]        cleared_r;
    logic              src_exh_r;

    // Next-state values
    state_t            state_n_s;
    logic [3:0]        col_n_s;
    logic [4:0]        src_n_s;
    logic [4:0]        dst_n_s;
    logic [4:0]        cleared_n_s;
    logic              src_exh_n_s;

    // Next values of the registered board-port outputs
    logic              busy_n_s;
    logic              done_n_s;
    logic              rd_act_s;
    logic [3:0]        rx_n_s;
    logic [4:0]        ry_n_s;
    logic              we_n_s;
    logic [3:0]        wx_n_s;
    logic [4:0]        wy_n_s;
    logic              wdata_n_s;

    // Row-buffer capture control
    logic              cap_en_s;
    logic [3:0]        cap_idx_s;
    logic              row_full_s;
    logic              src_last_s;

    // Read data lags the address by one cycle, so READ cycle k stores bit k-1.
    assign cap_en_s   = (state_r == READ) && (col_r != 4'd0);
    assign cap_idx_s  = col_r - 4'd1;
    assign row_full_s = &row_buf_r;
    // Row 0 is recognised before any decrement, so src never wraps into the scan.
    assign src_last_s = (src_r == 5'd0) || src_exh_r;

    assign lines_cleared = cleared_r;

    // Scan sequencing: next state, pointers, column counter and cleared count.
    always_comb begin
        state_n_s   = state_r;
        col_n_s     = col_r;
        src_n_s     = src_r;
        dst_n_s     = dst_r;
        cleared_n_s = cleared_r;
        src_exh_n_s = src_exh_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s   = READ;
                    col_n_s     = 4'd0;
                    src_n_s     = LAST_ROW;
                    dst_n_s     = LAST_ROW;
                    cleared_n_s = 5'd0;
                    src_exh_n_s = 1'b0;
                end else begin
                    state_n_s   = IDLE;
                end
            end

            READ: begin
                if (col_r == COL_END) begin
                    state_n_s = EVAL;
                    col_n_s   = 4'd0;
                end else begin
                    col_n_s   = col_r + 4'd1;
                end
            end

            EVAL: begin
                col_n_s = 4'd0;
                if (row_full_s) begin
                    // Drop the row: dst stays put so the next kept row lands here.
                    cleared_n_s = cleared_r + 5'd1;
                    if (src_last_s) begin
                        src_exh_n_s = 1'b1;
                        state_n_s   = FILL;
                    end else begin
                        src_n_s     = src_r - 5'd1;
                        state_n_s   = READ;
                    end
                end else if (src_r == dst_r) begin
                    // Row already in its final place, nothing to write.
                    if (src_last_s) begin
                        src_exh_n_s = 1'b1;
                        state_n_s   = (cleared_r != 5'd0) ? FILL : DONE;
                    end else begin
                        src_n_s     = src_r - 5'd1;
                        dst_n_s     = dst_r - 5'd1;
                        state_n_s   = READ;
                    end
                end else begin
                    state_n_s = COPY;
                end
            end

            COPY: begin
                if (col_r == LAST_COL) begin
                    col_n_s = 4'd0;
                    // dst > src here, so dst - 1 cannot underflow.
                    dst_n_s = dst_r - 5'd1;
                    if (src_last_s) begin
                        src_exh_n_s = 1'b1;
                        state_n_s   = (cleared_r != 5'd0) ? FILL : DONE;
                    end else begin
                        src_n_s     = src_r - 5'd1;
                        state_n_s   = READ;
                    end
                end else begin
                    col_n_s = col_r + 4'd1;
                end
            end

            FILL: begin
                if (col_r == LAST_COL) begin
                    col_n_s = 4'd0;
                    if (dst_r == 5'd0) begin
                        state_n_s = DONE;
                    end else begin
                        dst_n_s   = dst_r - 5'd1;
                    end
                end else begin
                    col_n_s = col_r + 4'd1;
                end
            end

            DONE: begin
                state_n_s = IDLE;
            end

            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Board-port outputs derived from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        busy_n_s  = (state_n_s != IDLE);
        done_n_s  = (state_n_s == DONE);
        rd_act_s  = (state_n_s == READ) && (col_n_s < COL_END);
        rx_n_s    = 4'd0;
        ry_n_s    = 5'd0;
        we_n_s    = (state_n_s == COPY) || (state_n_s == FILL);
        wx_n_s    = 4'd0;
        wy_n_s    = 5'd0;
        wdata_n_s = 1'b0;

        if (rd_act_s) begin
            rx_n_s = col_n_s;
        end else begin
            rx_n_s = 4'd0;
        end

        // ry follows src throughout the scan; zero only when idle/done.
        if (busy_n_s && !done_n_s) begin
            ry_n_s = src_n_s;
        end else begin
            ry_n_s = 5'd0;
        end

        if (we_n_s) begin
            wx_n_s = col_n_s;
            wy_n_s = dst_n_s;
        end else begin
            wx_n_s = 4'd0;
            wy_n_s = 5'd0;
        end

        // FILL writes zeros; COPY replays the captured row.
        if (state_n_s == COPY) begin
            wdata_n_s = row_buf_r[col_n_s];
        end else begin
            wdata_n_s = 1'b0;
        end
    end

    // State, pointer, counter and row-buffer registers.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r   <= IDLE;
            col_r     <= 4'd0;
            src_r     <= 5'd0;
            dst_r     <= 5'd0;
            row_buf_r <= '0;
            cleared_r <= 5'd0;
            src_exh_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            col_r     <= col_n_s;
            src_r     <= src_n_s;
            dst_r     <= dst_n_s;
            cleared_r <= cleared_n_s;
            src_exh_r <= src_exh_n_s;
            if (cap_en_s) begin
                row_buf_r[cap_idx_s] <= board_rdata;
            end
        end
    end

    // Registered status and board-port outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            board_rx    <= 4'd0;
            board_ry    <= 5'd0;
            board_we    <= 1'b0;
            board_wx    <= 4'd0;
            board_wy    <= 5'd0;
            board_wdata <= 1'b0;
        end else begin
            busy        <= busy_n_s;
            done        <= done_n_s;
            board_rx    <= rx_n_s;
            board_ry    <= ry_n_s;
            board_we    <= we_n_s;
            board_wx    <= wx_n_s;
            board_wy    <= wy_n_s;
            board_wdata <= wdata_n_s;
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_clear_ctrl
//
// Self-checking bench for line_clear_ctrl. A behavioural board memory with a
// synchronous read port sits on the DUT's board interface. Each scan pushes
// the reference result (compacted board, cleared count, write count, cycle
// count) onto a queue; the result is popped and compared when done arrives.
// -----------------------------------------------------------------------------
module tb_line_clear_ctrl;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int TMO  = 3000;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct {
        logic [4:0] lc;
        int         writes;
        int         cycles;
        board_t     fin;
    } exp_t;

    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;
    logic [3:0] board_rx;
    logic [4:0] board_ry;
    logic       board_rdata;
    logic       board_we;
    logic [3:0] board_wx;
    logic [4:0] board_wy;
    logic       board_wdata;

    exp_t   exp_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;

    board_t board_mem;
    board_t load_val;
    logic   load_req;

    int     cyc_cnt   = 0;
    int     wr_cnt    = 0;
    int     done_cnt  = 0;
    int     idle_err  = 0;
    int     order_err = 0;
    int     min_read  = ROWS;

    line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .board_rx      (board_rx),
        .board_ry      (board_ry),
        .board_rdata   (board_rdata),
        .board_we      (board_we),
        .board_wx      (board_wx),
        .board_wy      (board_wy),
        .board_wdata   (board_wdata)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Board memory: bulk load from the bench, cell writes and sync read from the DUT.
    always @(posedge CLOCK_50) begin
        if (load_req) begin
            board_mem <= load_val;
        end else if (board_we && int'(board_wy) < ROWS && int'(board_wx) < COLS) begin
            board_mem[board_wy][board_wx] <= board_wdata;
        end
        if (int'(board_ry) < ROWS && int'(board_rx) < COLS) begin
            board_rdata <= board_mem[board_ry][board_rx];
        end else begin
            board_rdata <= 1'b0;
        end
    end

    // Monitor: cycle/write/done counts plus port-discipline checks.
    always @(negedge CLOCK_50) begin
        if (busy && !done) cyc_cnt = cyc_cnt + 1;
        if (board_we) wr_cnt = wr_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (!busy || done) begin
            if (board_we || board_rx != 4'd0 || board_ry != 5'd0 ||
                board_wx != 4'd0 || board_wy != 5'd0 || board_wdata)
                idle_err = idle_err + 1;
        end
        if (!busy) begin
            min_read = ROWS;
        end else if (!done && int'(board_ry) < min_read) begin
            min_read = int'(board_ry);
        end
        if (board_we && int'(board_wy) < min_read) order_err = order_err + 1;
    end

    // Reference compaction: keep non-full rows in order, packed to the bottom.
    function automatic exp_t model(input board_t b);
        exp_t e;
        int   dst;
        int   cleared;
        int   copies;
        e.fin   = '0;
        dst     = ROWS - 1;
        cleared = 0;
        copies  = 0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            if (b[y] == {COLS{1'b1}}) begin
                cleared++;
            end else begin
                e.fin[dst] = b[y];
                if (dst != y) copies++;
                dst--;
            end
        end
        e.lc     = 5'(cleared);
        e.writes = COLS * (copies + cleared);
        e.cycles = ROWS * (COLS + 2) + e.writes;
        return e;
    endfunction

    task automatic load_board(input board_t b);
        load_val = b;
        load_req = 1'b1;
        @(negedge CLOCK_50);
        load_req = 1'b0;
    endtask

    // Loads a board, starts a scan (optionally re-pulsing start at cycle extra_at)
    // and waits for done; returns the observed results.
    task automatic do_scan(input board_t b, input int extra_at,
                           output logic [4:0] lc, output int wr, output int cyc,
                           output int dn, output logic to, output logic busy_after);
        int w0;
        int c0;
        int d0;
        int t;
        load_board(b);
        exp_q.push_back(model(b));
        w0 = wr_cnt;
        c0 = cyc_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < TMO) begin
            @(negedge CLOCK_50);
            t++;
            if (t == extra_at) begin
                start = 1'b1;
                @(negedge CLOCK_50);
                start = 1'b0;
                t++;
            end
        end
        to = (t >= TMO);
        lc = lines_cleared;
        repeat (3) @(negedge CLOCK_50);
        busy_after = busy;
        wr  = wr_cnt - w0;
        cyc = cyc_cnt - c0;
        dn  = done_cnt - d0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 5'd0 || board_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got busy=%b done=%b lc=%0d we=%b required 0/0/0/0",
                     busy, done, lines_cleared, board_we);
        end
        tests_run++;
        if (board_rx !== 4'd0 || board_ry !== 5'd0 || board_wx !== 4'd0 ||
            board_wy !== 5'd0 || board_wdata !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_addr: got rx=%0d ry=%0d wx=%0d wy=%0d wd=%b required all 0",
                     board_rx, board_ry, board_wx, board_wy, board_wdata);
        end
        resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_empty();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        b = '0;
        do_scan(b, 0, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL empty_timeout: no done within %0d cycles", TMO); end
        tests_run++;
        if (cyc != 240 || cyc != e.cycles) begin tests_failed++; $display("FAIL empty_cycles: got %0d required 240", cyc); end
        tests_run++;
        if (wr != 0) begin tests_failed++; $display("FAIL empty_writes: got %0d required 0", wr); end
        tests_run++;
        if (lc !== e.lc || dn != 1 || ba !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_done: got lc=%0d dones=%0d busy=%b required %0d/1/0", lc, dn, ba, e.lc);
        end
    endtask

    task automatic test_one_line();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        b = '0;
        b[19] = {COLS{1'b1}};
        b[18][4] = 1'b1;
        do_scan(b, 0, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (lc !== 5'd1 || lc !== e.lc) begin tests_failed++; $display("FAIL one_line_lc: got %0d required 1", lc); end
        tests_run++;
        if (wr != 200 || cyc != e.cycles) begin
            tests_failed++;
            $display("FAIL one_line_counts: got writes=%0d cycles=%0d required 200/%0d", wr, cyc, e.cycles);
        end
        tests_run++;
        if (board_mem !== e.fin || board_mem[19][4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL one_line_board: got %h required %h", board_mem, e.fin);
        end
        tests_run++;
        if (dn != 1 || to) begin tests_failed++; $display("FAIL one_line_done: got %0d pulses required 1", dn); end
    endtask

    task automatic test_four_lines();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        b = '0;
        for (int y = 16; y < 20; y++) b[y] = {COLS{1'b1}};
        b[15][3] = 1'b1;
        do_scan(b, 0, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (lc !== 5'd4 || lc !== e.lc) begin tests_failed++; $display("FAIL four_lines_lc: got %0d required 4", lc); end
        tests_run++;
        if (board_mem !== e.fin || board_mem[19][3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL four_lines_board: got %h required %h", board_mem, e.fin);
        end
        tests_run++;
        if (wr != e.writes || cyc != e.cycles || dn != 1 || to) begin
            tests_failed++;
            $display("FAIL four_lines_counts: got writes=%0d cycles=%0d dones=%0d required %0d/%0d/1",
                     wr, cyc, dn, e.writes, e.cycles);
        end
    endtask

    task automatic test_full_board();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        b = '1;
        do_scan(b, 0, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (lc !== 5'd20 || lc !== e.lc) begin tests_failed++; $display("FAIL full_lc: got %0d required 20", lc); end
        tests_run++;
        if (wr != 200 || cyc != 440) begin
            tests_failed++;
            $display("FAIL full_counts: got writes=%0d cycles=%0d required 200/440", wr, cyc);
        end
        tests_run++;
        if (board_mem !== '0 || dn != 1 || to) begin
            tests_failed++;
            $display("FAIL full_board: got board=%h dones=%0d required 0/1", board_mem, dn);
        end
    endtask

    task automatic test_random();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        for (int n = 0; n < 4; n++) begin
            for (int y = 0; y < ROWS; y++) begin
                if ($urandom_range(0, 2) == 0) b[y] = {COLS{1'b1}};
                else b[y] = COLS'($urandom);
            end
            do_scan(b, 0, lc, wr, cyc, dn, to, ba);
            e = exp_q.pop_front();
            tests_run++;
            if (lc !== e.lc || board_mem !== e.fin) begin
                tests_failed++;
                $display("FAIL random%0d_result: got lc=%0d board=%h required lc=%0d board=%h",
                         n, lc, board_mem, e.lc, e.fin);
            end
            tests_run++;
            if (wr != e.writes || cyc != e.cycles || dn != 1 || to || ba !== 1'b0) begin
                tests_failed++;
                $display("FAIL random%0d_counts: got writes=%0d cycles=%0d dones=%0d required %0d/%0d/1",
                         n, wr, cyc, dn, e.writes, e.cycles);
            end
        end
    endtask

    task automatic test_back_to_back_start();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        b = '0;
        b[19] = {COLS{1'b1}};
        b[17] = {COLS{1'b1}};
        b[10][2] = 1'b1;
        b[5][7]  = 1'b1;
        do_scan(b, 40, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (dn != 1 || to) begin tests_failed++; $display("FAIL busy_start_done: got %0d pulses required 1", dn); end
        tests_run++;
        if (lc !== e.lc || lines_cleared !== e.lc) begin
            tests_failed++;
            $display("FAIL busy_start_lc: got %0d (held %0d) required %0d", lc, lines_cleared, e.lc);
        end
        tests_run++;
        if (board_mem !== e.fin || cyc != e.cycles) begin
            tests_failed++;
            $display("FAIL busy_start_board: got cycles=%0d required %0d", cyc, e.cycles);
        end
    endtask

    task automatic test_reset_mid_copy();
        board_t b;
        exp_t e;
        logic [4:0] lc;
        int wr, cyc, dn;
        logic to, ba;
        int t;
        int d0;
        b = '0;
        b[19] = {COLS{1'b1}};
        b[18][4] = 1'b1;
        load_board(b);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        t = 0;
        while (board_we !== 1'b1 && t < TMO) begin
            @(negedge CLOCK_50);
            t++;
        end
        tests_run++;
        if (t >= TMO) begin tests_failed++; $display("FAIL rst_copy_reach: no write seen within %0d cycles", TMO); end
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge CLOCK_50);
        tests_run++;
        if (busy !== 1'b0 || board_we !== 1'b0 || lines_cleared !== 5'd0) begin
            tests_failed++;
            $display("FAIL rst_copy_abort: got busy=%b we=%b lc=%0d required 0/0/0", busy, board_we, lines_cleared);
        end
        resetn = 1'b1;
        repeat (500) @(negedge CLOCK_50);
        tests_run++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_copy_nodone: got %0d pulses busy=%b required 0/0", done_cnt - d0, busy);
        end
        do_scan(b, 0, lc, wr, cyc, dn, to, ba);
        e = exp_q.pop_front();
        tests_run++;
        if (lc !== e.lc || board_mem !== e.fin || wr != e.writes || dn != 1 || to) begin
            tests_failed++;
            $display("FAIL rst_copy_rescan: got lc=%0d writes=%0d dones=%0d required %0d/%0d/1",
                     lc, wr, dn, e.lc, e.writes);
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (idle_err != 0) begin
            tests_failed++;
            $display("FAIL idle_port: got %0d cycles with nonzero port while idle/done required 0", idle_err);
        end
        tests_run++;
        if (order_err != 0) begin
            tests_failed++;
            $display("FAIL write_order: got %0d writes to unread rows required 0", order_err);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_left: got %0d entries required 0", exp_q.size());
        end
    endtask

    initial begin
        load_req = 1'b0;
        load_val = '0;
        start    = 1'b0;
        resetn   = 1'b0;
        test_reset();
        test_empty();
        test_one_line();
        test_four_lines();
        test_full_board();
        test_random();
        test_back_to_back_start();
        test_reset_mid_copy();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
